// File: rtl/arm_pkg.sv
// ----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARM-style status register slice:
//   - condition code encodings (EQ..AL)
//   - NZCV flag bit positions within the flag vector (MSB = N)
//   - flag vector width
//   - state type of the CPSR/SPSR shadow FSM
// ----------------------------------------------------------------------------
package arm_pkg;

    localparam int FLAG_W = 4;

    // Flag bit positions inside an NZCV vector.
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // Condition field encodings.
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    // Encoding 15 behaves as "always" too, so it never needs flags.
    localparam logic [3:0] COND_NV = 4'd15;

    // NORMAL: no saved context.  SAVED: SPSR holds a context.
    typedef enum logic {
        NORMAL = 1'b0,
        SAVED  = 1'b1
    } sr_state_t;

    // True when a condition field does not depend on the flags at all.
    function automatic logic cond_is_unconditional(input logic [3:0] cond,
                                                   input logic [3:0] al_code);
        return (cond == al_code) || (cond == COND_NV);
    endfunction

endpackage

// File: rtl/flag_next_mux.sv
// ----------------------------------------------------------------------------
// flag_next_mux
// Combinational priority chain that produces the next CPSR flag value.
// Priority, highest first: accepted restore, masked MSR write, ALU update
// with S bit, hold.  Lower-priority sources in the same cycle are dropped.
//
// Ports:
//   cpsr       in  FLAG_W  current registered flags
//   spsr       in  FLAG_W  shadow flags (restore source)
//   restore    in  1       restore accepted by the FSM this cycle
//   msr_we     in  1       direct flag write
//   msr_mask   in  FLAG_W  per-bit write enable for msr_data
//   msr_data   in  FLAG_W  direct write data
//   alu_we     in  1       valid flag-setting ALU instruction in EXE
//   alu_nzcv   in  FLAG_W  ALU-produced flags
//   nzcv_next  out FLAG_W  next CPSR value
// ----------------------------------------------------------------------------
module flag_next_mux #(
    parameter int FLAG_W = 4
) (
    input  logic [FLAG_W-1:0] cpsr,
    input  logic [FLAG_W-1:0] spsr,
    input  logic              restore,
    input  logic              msr_we,
    input  logic [FLAG_W-1:0] msr_mask,
    input  logic [FLAG_W-1:0] msr_data,
    input  logic              alu_we,
    input  logic [FLAG_W-1:0] alu_nzcv,
    output logic [FLAG_W-1:0] nzcv_next
);

    always_comb begin
        nzcv_next = cpsr;
        if (restore) begin
            nzcv_next = spsr;
        end else if (msr_we) begin
            // Unmasked bits keep their current value.
            nzcv_next = (msr_data & msr_mask) | (cpsr & ~msr_mask);
        end else if (alu_we) begin
            nzcv_next = alu_nzcv;
        end
    end

endmodule

// File: rtl/status_register_unit.sv
// ----------------------------------------------------------------------------
// status_register_unit
// Holds the architectural NZCV flags (CPSR condition field), a single-level
// SPSR shadow for exception entry/return, and the ID/EXE flag hazard check.
//
// Configuration macro: STATUS_REG_FLAG_BYPASS_EN
//   undefined (default): nzcv_out is the registered CPSR, flag_hazard active.
//   defined            : nzcv_out is the CPSR next value (same-cycle
//                        visibility), flag_hazard tied low.
//
// Ports:
//   clk          in  1       rising-edge clock
//   rst          in  1       asynchronous active-low reset
//   exe_valid    in  1       EXE stage holds a valid instruction
//   exe_s        in  1       EXE instruction sets flags
//   alu_nzcv     in  FLAG_W  ALU flags this cycle
//   msr_we       in  1       direct flag write request
//   msr_mask     in  FLAG_W  per-bit write enable for msr_data
//   msr_data     in  FLAG_W  direct write data
//   save_req     in  1       exception entry: CPSR -> SPSR
//   restore_req  in  1       exception return: SPSR -> CPSR
//   id_valid     in  1       ID stage holds a valid instruction
//   id_cond      in  4       condition field of the ID instruction
//   nzcv_out     out FLAG_W  flags to the condition check
//   spsr_out     out FLAG_W  shadow flags
//   spsr_valid   out 1       shadow holds a saved value
//   flag_hazard  out 1       stall request
//   seq_err      out 1       one-cycle pulse on illegal save/restore
// ----------------------------------------------------------------------------
module status_register_unit
    import arm_pkg::*;
#(
    parameter int                FLAG_W      = arm_pkg::FLAG_W,
    parameter logic [FLAG_W-1:0] RESET_FLAGS = '0,
    parameter logic [3:0]        AL_CODE     = 4'd14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_s,
    input  logic [FLAG_W-1:0] alu_nzcv,
    input  logic              msr_we,
    input  logic [FLAG_W-1:0] msr_mask,
    input  logic [FLAG_W-1:0] msr_data,
    input  logic              save_req,
    input  logic              restore_req,
    input  logic              id_valid,
    input  logic [3:0]        id_cond,
    output logic [FLAG_W-1:0] nzcv_out,
    output logic [FLAG_W-1:0] spsr_out,
    output logic              spsr_valid,
    output logic              flag_hazard,
    output logic              seq_err
);

    sr_state_t         state;
    sr_state_t         state_next;
    logic [FLAG_W-1:0] cpsr;
    logic [FLAG_W-1:0] spsr;
    logic [FLAG_W-1:0] cpsr_next;
    logic              save_acc;
    logic              restore_acc;
    logic              err_event;
    logic              alu_we;

    assign alu_we = exe_valid & exe_s;

    // FSM next state and accept/error decode.  In SAVED a simultaneous
    // save is silently swallowed by the restore; in NORMAL the save wins
    // and the stray restore is reported.
    always_comb begin
        state_next  = state;
        save_acc    = 1'b0;
        restore_acc = 1'b0;
        err_event   = 1'b0;
        case (state)
            NORMAL: begin
                if (save_req) begin
                    save_acc   = 1'b1;
                    state_next = SAVED;
                end
                if (restore_req) begin
                    err_event = 1'b1;
                end
            end
            SAVED: begin
                if (restore_req) begin
                    restore_acc = 1'b1;
                    state_next  = NORMAL;
                end else if (save_req) begin
                    err_event = 1'b1;
                end
            end
            default: begin
                state_next = NORMAL;
            end
        endcase
    end

    flag_next_mux #(
        .FLAG_W (FLAG_W)
    ) u_flag_next_mux (
        .cpsr      (cpsr),
        .spsr      (spsr),
        .restore   (restore_acc),
        .msr_we    (msr_we),
        .msr_mask  (msr_mask),
        .msr_data  (msr_data),
        .alu_we    (alu_we),
        .alu_nzcv  (alu_nzcv),
        .nzcv_next (cpsr_next)
    );

    // State, flag and shadow registers.  SPSR captures the pre-update CPSR
    // of the save cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= NORMAL;
            cpsr    <= RESET_FLAGS;
            spsr    <= '0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_next;
            cpsr    <= cpsr_next;
            seq_err <= err_event;
            if (save_acc) begin
                spsr <= cpsr;
            end
        end
    end

    assign spsr_out   = spsr;
    assign spsr_valid = (state == SAVED);

`ifdef STATUS_REG_FLAG_BYPASS_EN
    // Same-cycle visibility: the condition check sees the value being written.
    assign nzcv_out    = cpsr_next;
    assign flag_hazard = 1'b0;
`else
    // A flag-reading instruction in ID must wait while any flag writer is
    // active in the same cycle; flag contents never enter this term.
    assign nzcv_out    = cpsr;
    assign flag_hazard = id_valid & ~cond_is_unconditional(id_cond, AL_CODE)
                         & (alu_we | msr_we | restore_acc);
`endif

endmodule

// File: tb/tb_status_register_unit.sv
// ----------------------------------------------------------------------------
// tb_status_register_unit
// Directed bench for status_register_unit.  Expectations are queued as the
// stimulus is applied and drained against the DUT outputs by checkOutput.
// ----------------------------------------------------------------------------
module tb_status_register_unit;

    localparam int K_NZCV   = 0;
    localparam int K_SPSR   = 1;
    localparam int K_VALID  = 2;
    localparam int K_SEQERR = 3;
    localparam int K_HAZARD = 4;

    typedef struct {
        string      tag;
        int         kind;
        logic [3:0] exp;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       exe_valid;
    logic       exe_s;
    logic [3:0] alu_nzcv;
    logic       msr_we;
    logic [3:0] msr_mask;
    logic [3:0] msr_data;
    logic       save_req;
    logic       restore_req;
    logic       id_valid;
    logic [3:0] id_cond;
    logic [3:0] nzcv_out;
    logic [3:0] spsr_out;
    logic       spsr_valid;
    logic       flag_hazard;
    logic       seq_err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef STATUS_REG_FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    status_register_unit #(
        .FLAG_W      (4),
        .RESET_FLAGS (4'b0000),
        .AL_CODE     (4'd14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exe_valid   (exe_valid),
        .exe_s       (exe_s),
        .alu_nzcv    (alu_nzcv),
        .msr_we      (msr_we),
        .msr_mask    (msr_mask),
        .msr_data    (msr_data),
        .save_req    (save_req),
        .restore_req (restore_req),
        .id_valid    (id_valid),
        .id_cond     (id_cond),
        .nzcv_out    (nzcv_out),
        .spsr_out    (spsr_out),
        .spsr_valid  (spsr_valid),
        .flag_hazard (flag_hazard),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one expectation.
    task automatic pushExp(input string tag, input int kind, input logic [3:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Drain every queued expectation against the current DUT outputs.
    task automatic checkOutput();
        exp_t       e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_NZCV:   obs = nzcv_out;
                K_SPSR:   obs = spsr_out;
                K_VALID:  obs = {3'b000, spsr_valid};
                K_SEQERR: obs = {3'b000, seq_err};
                default:  obs = {3'b000, flag_hazard};
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idleInputs();
        exe_valid   = 1'b0;
        exe_s       = 1'b0;
        alu_nzcv    = 4'b0000;
        msr_we      = 1'b0;
        msr_mask    = 4'b0000;
        msr_data    = 4'b0000;
        save_req    = 1'b0;
        restore_req = 1'b0;
        id_valid    = 1'b0;
        id_cond     = 4'd0;
    endtask

    // Drive one cycle's worth of inputs on the falling edge.
    task automatic applyStimulus(input logic ev, input logic es, input logic [3:0] alu,
                                 input logic mw, input logic [3:0] mm, input logic [3:0] md,
                                 input logic sv, input logic rs,
                                 input logic iv, input logic [3:0] ic);
        @(negedge clk);
        exe_valid   = ev;
        exe_s       = es;
        alu_nzcv    = alu;
        msr_we      = mw;
        msr_mask    = mm;
        msr_data    = md;
        save_req    = sv;
        restore_req = rs;
        id_valid    = iv;
        id_cond     = ic;
        #1;
    endtask

    // Let the rising edge capture, then return inputs to idle.
    task automatic clockEdge();
        @(posedge clk);
        #1;
        idleInputs();
        #1;
    endtask

    initial begin
        $display("[TB] start, bypass=%0d", BYPASS);
        idleInputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pushExp("reset_nzcv",   K_NZCV,   4'b0000);
        pushExp("reset_spsr",   K_SPSR,   4'b0000);
        pushExp("reset_valid",  K_VALID,  4'd0);
        pushExp("reset_seqerr", K_SEQERR, 4'd0);
        pushExp("reset_hazard", K_HAZARD, 4'd0);
        checkOutput();
        @(negedge clk);
        rst = 1'b1;

        // ALU update with S bit
        applyStimulus(1, 1, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        pushExp("alu_same_cycle", K_NZCV, BYPASS ? 4'b0100 : 4'b0000);
        checkOutput();
        clockEdge();
        pushExp("alu_update", K_NZCV, 4'b0100);
        checkOutput();

        // S bit clear leaves flags alone
        applyStimulus(1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        clockEdge();
        pushExp("alu_no_s", K_NZCV, 4'b0100);
        checkOutput();

        // MSR masked write beats a simultaneous ALU update
        applyStimulus(1, 1, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        clockEdge();
        pushExp("set_1111", K_NZCV, 4'b1111);
        checkOutput();
        applyStimulus(1, 1, 4'b0100, 1, 4'b0011, 4'b0000, 0, 0, 0, 4'd0);
        clockEdge();
        pushExp("msr_masked", K_NZCV, 4'b1100);
        checkOutput();

        // Save, overwrite, restore
        applyStimulus(1, 1, 4'b1010, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        clockEdge();
        pushExp("set_1010", K_NZCV, 4'b1010);
        checkOutput();
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'd0);
        clockEdge();
        pushExp("save_spsr",   K_SPSR,   4'b1010);
        pushExp("save_valid",  K_VALID,  4'd1);
        pushExp("save_seqerr", K_SEQERR, 4'd0);
        checkOutput();
        applyStimulus(1, 1, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        clockEdge();
        pushExp("alu_in_saved", K_NZCV, 4'b0001);
        checkOutput();
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 1, 4'd0);
        pushExp("restore_hazard", K_HAZARD, BYPASS ? 4'd0 : 4'd1);
        checkOutput();
        clockEdge();
        pushExp("restore_nzcv",  K_NZCV,  4'b1010);
        pushExp("restore_valid", K_VALID, 4'd0);
        checkOutput();

        // Restore in NORMAL is an error
        applyStimulus(1, 1, 4'b0111, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'd0);
        clockEdge();
        pushExp("bad_restore_err",  K_SEQERR, 4'd1);
        pushExp("bad_restore_nzcv", K_NZCV,   4'b0111);
        pushExp("bad_restore_val",  K_VALID,  4'd0);
        checkOutput();
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        clockEdge();
        pushExp("bad_restore_pulse_end", K_SEQERR, 4'd0);
        checkOutput();

        // Nested save is an error, SPSR kept
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'd0);
        clockEdge();
        pushExp("save2_spsr", K_SPSR, 4'b0111);
        checkOutput();
        applyStimulus(1, 1, 4'b0101, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'd0);
        clockEdge();
        pushExp("nested_err",  K_SEQERR, 4'd1);
        pushExp("nested_spsr", K_SPSR,   4'b0111);
        pushExp("nested_val",  K_VALID,  4'd1);
        pushExp("nested_nzcv", K_NZCV,   4'b0101);
        checkOutput();
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        clockEdge();
        pushExp("nested_pulse_end", K_SEQERR, 4'd0);
        checkOutput();

        // Save+restore in SAVED: restore wins, no error
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 1, 0, 4'd0);
        clockEdge();
        pushExp("both_saved_nzcv", K_NZCV,   4'b0111);
        pushExp("both_saved_val",  K_VALID,  4'd0);
        pushExp("both_saved_err",  K_SEQERR, 4'd0);
        checkOutput();

        // Save+restore in NORMAL: save wins, error
        applyStimulus(1, 1, 4'b1001, 0, 4'b0000, 4'b0000, 1, 1, 0, 4'd0);
        clockEdge();
        pushExp("both_normal_val",  K_VALID,  4'd1);
        pushExp("both_normal_spsr", K_SPSR,   4'b0111);
        pushExp("both_normal_err",  K_SEQERR, 4'd1);
        pushExp("both_normal_nzcv", K_NZCV,   4'b1001);
        checkOutput();

        // Hazard detection (state is SAVED here)
        applyStimulus(1, 1, 4'b0110, 0, 4'b0000, 4'b0000, 0, 0, 1, 4'd0);
        pushExp("hazard_eq", K_HAZARD, BYPASS ? 4'd0 : 4'd1);
        checkOutput();
        clockEdge();
        pushExp("hazard_eq_nzcv", K_NZCV, 4'b0110);
        checkOutput();
        applyStimulus(1, 1, 4'b0110, 0, 4'b0000, 4'b0000, 0, 0, 1, 4'd14);
        pushExp("hazard_al", K_HAZARD, 4'd0);
        checkOutput();
        clockEdge();
        applyStimulus(1, 1, 4'b0110, 0, 4'b0000, 4'b0000, 0, 0, 1, 4'd15);
        pushExp("hazard_15", K_HAZARD, 4'd0);
        checkOutput();
        clockEdge();
        applyStimulus(1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 1, 4'd1);
        pushExp("hazard_no_writer", K_HAZARD, 4'd0);
        checkOutput();
        clockEdge();
        applyStimulus(0, 0, 4'b0000, 1, 4'b0000, 4'b0110, 0, 0, 1, 4'd1);
        pushExp("hazard_msr", K_HAZARD, BYPASS ? 4'd0 : 4'd1);
        checkOutput();
        clockEdge();
        pushExp("hazard_retired", K_HAZARD, 4'd0);
        pushExp("pre_reset_nzcv", K_NZCV,   4'b0110);
        pushExp("pre_reset_val",  K_VALID,  4'd1);
        checkOutput();

        // Asynchronous reset mid-cycle while SAVED with CPSR=0110
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        pushExp("async_nzcv", K_NZCV,  4'b0000);
        pushExp("async_val",  K_VALID, 4'd0);
        pushExp("async_spsr", K_SPSR,  4'b0000);
        checkOutput();
        @(negedge clk);
        rst = 1'b1;

        // FSM is back in NORMAL: a restore must be flagged as an error
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'd0);
        clockEdge();
        pushExp("post_reset_err",  K_SEQERR, 4'd1);
        pushExp("post_reset_nzcv", K_NZCV,   4'b0000);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
